memory_vector: RTL and testbench

- Byte-addressable vector scratch memory, 8 rows x 256 bits (256 bytes), sitting between the conv engine's vector load path and its adder array.
- Host side: byte write/read via column address.
- Adder side: full 256-bit row write from the adder (WWL one-hot) and full-row read to the adder (RWL one-hot).

---
 rtl/memv_pkg.sv | 13 +
 rtl/memory_vector_if.sv | 26 ++
 rtl/memv_row.sv | 32 +++
 rtl/memory_vector.sv | 76 +++++++
 tb/tb_memory_vector.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/memv_pkg.sv
// Shared constants and types for the memory_vector scratch memory.
// The optional write-through forwarding path is enabled with MEMV_BYPASS_EN.
package memv_pkg;
  localparam int ROWS          = 8;
  localparam int ROW_W         = 256;
  localparam int BYTE_W        = 8;
  localparam int ADDR_W        = 8;
  localparam int BYTES_PER_ROW = ROW_W / BYTE_W;
  localparam int COL_W         = $clog2(BYTES_PER_ROW);
  localparam int ROW_SEL_W     = $clog2(ROWS);

  typedef logic [ROW_W-1:0] row_t;
endpackage

// File: rtl/memory_vector_if.sv
// Host byte port plus adder row port of the vector scratch memory.
interface memory_vector_if;
  import memv_pkg::*;

  logic              En;
  logic [BYTE_W-1:0] DataIn;
  logic [ADDR_W-1:0] Col_ADDRS;
  logic              Write;
  logic              READ;
  logic [BYTE_W-1:0] DataOut;
  logic [ROWS-1:0]   WWL;
  row_t              FromAdder;
  logic [ROWS-1:0]   RWL;
  row_t              ToAdder;
  logic              Clr;

  modport master (
    output En, DataIn, Col_ADDRS, Write, READ, WWL, FromAdder, RWL, Clr,
    input  DataOut, ToAdder
  );

  modport slave (
    input  En, DataIn, Col_ADDRS, Write, READ, WWL, FromAdder, RWL, Clr,
    output DataOut, ToAdder
  );
endinterface

// File: rtl/memv_row.sv
// One 256-bit storage row: async reset, sync clear, full-row load, byte writes.
module memv_row
  import memv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  row_t                     i_load_data,
  input  logic [BYTES_PER_ROW-1:0] i_byte_we,
  input  logic [BYTE_W-1:0]        i_byte_data,
  output row_t                     o_row
);
  row_t r_row;

  // Clear beats a full-row load, which beats any byte write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
    end else if (i_clr) begin
      r_row <= '0;
    end else if (i_load) begin
      r_row <= i_load_data;
    end else begin
      for (int b = 0; b < BYTES_PER_ROW; b++) begin
        if (i_byte_we[b]) r_row[b*BYTE_W +: BYTE_W] <= i_byte_data;
      end
    end
  end

  assign o_row = r_row;
endmodule

// File: rtl/memory_vector.sv
// 8x256-bit vector scratch memory: host byte port plus adder row port.
// Define MEMV_BYPASS_EN for write-through forwarding on same-cycle read/write.
module memory_vector
  import memv_pkg::*;
(
  input logic              clk,
  input logic              rst,
  memory_vector_if.slave   bus
);
  logic [ROW_SEL_W-1:0]                           w_row_sel;
  logic [COL_W-1:0]                               w_col;
  logic                                           w_host_we;
  logic                                           w_host_rd;
  logic [ROWS-1:0][BYTES_PER_ROW-1:0][BYTE_W-1:0] w_rows;
  logic [BYTES_PER_ROW-1:0][BYTE_W-1:0]           w_from_bytes;
  logic [BYTE_W-1:0]                              w_rd_data;
  row_t                                           w_to_adder;
  logic [BYTE_W-1:0]                              r_dout;

  assign w_row_sel    = bus.Col_ADDRS[ADDR_W-1 -: ROW_SEL_W];
  assign w_col        = bus.Col_ADDRS[COL_W-1:0];
  assign w_from_bytes = bus.FromAdder;

  // Any adder row write suppresses the host byte write, whatever its row.
  assign w_host_we = bus.En & bus.Write & ~bus.Clr & ~(|bus.WWL);
  assign w_host_rd = bus.En & bus.READ;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [BYTES_PER_ROW-1:0] w_byte_we;
    assign w_byte_we = (w_host_we && (w_row_sel == ROW_SEL_W'(r)))
                       ? (BYTES_PER_ROW'(1) << w_col) : '0;

    memv_row u_row (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (bus.Clr),
      .i_load      (bus.WWL[r]),
      .i_load_data (bus.FromAdder),
      .i_byte_we   (w_byte_we),
      .i_byte_data (bus.DataIn),
      .o_row       (w_rows[r])
    );
  end

  // Read and write share Col_ADDRS, so a same-cycle read+write always hits one byte.
  always_comb begin
    w_rd_data = w_rows[w_row_sel][w_col];
`ifdef MEMV_BYPASS_EN
    if (bus.WWL[w_row_sel]) begin
      w_rd_data = w_from_bytes[w_col];
    end else if (w_host_we) begin
      w_rd_data = bus.DataIn;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (bus.Clr) begin
      r_dout <= '0;
    end else if (w_host_rd) begin
      r_dout <= w_rd_data;
    end
  end

  always_comb begin
    w_to_adder = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (bus.RWL[r]) w_to_adder = w_to_adder | w_rows[r];
    end
  end

  assign bus.DataOut = r_dout;
  assign bus.ToAdder = w_to_adder;
endmodule

// File: tb/tb_memory_vector.sv
// Scoreboard bench for memory_vector: host byte port, adder row port, priority, reset.
module tb_memory_vector;
  import memv_pkg::*;

  logic clk;
  logic rst;
  memory_vector_if bus ();

  memory_vector dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [ROW_W-1:0]  exp_q[$];
  string             tag_q[$];
  logic [ROW_W-1:0]  m_row[ROWS];
  logic [BYTE_W-1:0] m_dout;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic [ROW_W-1:0] obs);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_row[r] = '0;
    m_dout = '0;
  endtask

  // Called at a falling edge: drive one cycle, predict DataOut, check it at the next falling edge.
  task automatic cyc(input string tag, input logic en, input logic wr, input logic rd,
                     input logic [7:0] addr, input logic [7:0] din, input logic [7:0] wwl,
                     input logic [ROW_W-1:0] from, input logic clr);
    logic [BYTE_W-1:0] exp;
    int row, col;
    row = int'(addr[7:5]);
    col = int'(addr[4:0]);
    bus.En = en; bus.Write = wr; bus.READ = rd; bus.Col_ADDRS = addr;
    bus.DataIn = din; bus.WWL = wwl; bus.FromAdder = from; bus.Clr = clr;
    exp = m_dout;
    if (clr) exp = '0;
    else if (en && rd) begin
      exp = m_row[row][col*8 +: 8];
`ifdef MEMV_BYPASS_EN
      if (wwl[row]) exp = from[col*8 +: 8];
      else if (wwl == 0 && wr) exp = din;
`endif
    end
    exp_q.push_back(ROW_W'(exp));
    tag_q.push_back(tag);
    if (clr) begin
      for (int r = 0; r < ROWS; r++) m_row[r] = '0;
    end else if (wwl != 0) begin
      for (int r = 0; r < ROWS; r++) if (wwl[r]) m_row[r] = from;
    end else if (en && wr) begin
      m_row[row][col*8 +: 8] = din;
    end
    m_dout = exp;
    @(posedge clk);
    @(negedge clk);
    pop_chk(ROW_W'(bus.DataOut));
    bus.En = 0; bus.Write = 0; bus.READ = 0; bus.WWL = '0; bus.Clr = 0;
  endtask

  task automatic adder_chk(input string tag, input logic [7:0] rwl);
    logic [ROW_W-1:0] exp;
    exp = '0;
    for (int r = 0; r < ROWS; r++) if (rwl[r]) exp = exp | m_row[r];
    bus.RWL = rwl;
    #1;
    chk(tag, bus.ToAdder, exp);
  endtask

  logic [ROW_W-1:0] ones;
  logic [ROW_W-1:0] pat;
  logic [ROW_W-1:0] sweep_row0;

  initial begin
    ones = '1;
    for (int k = 0; k < BYTES_PER_ROW; k++) pat[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < BYTES_PER_ROW; k++) sweep_row0[k*8 +: 8] = 8'(k);
    bus.En = 0; bus.Write = 0; bus.READ = 0; bus.Col_ADDRS = '0; bus.DataIn = '0;
    bus.WWL = '0; bus.FromAdder = '0; bus.RWL = '0; bus.Clr = 0;
    model_reset();
    rst = 1'b1;
    #12;
    chk("reset_dout", ROW_W'(bus.DataOut), '0);
    bus.RWL = 8'hFF; #1;
    chk("reset_toadder", bus.ToAdder, '0);
    @(negedge clk);
    rst = 1'b0;

    // Clear wins over a full-array row load.
    cyc("clr_dout", 1, 0, 0, 8'h00, 8'h00, 8'hFF, ones, 1);
    adder_chk("clr_toadder", 8'hFF);

    // Host sweep: write then read every byte.
    for (int i = 0; i < 256; i++) begin
      cyc("sweep_wr_hold", 1, 1, 0, 8'(i), 8'(i), 8'h00, '0, 0);
      cyc($sformatf("sweep_rd_%0d", i), 1, 0, 1, 8'(i), 8'h00, 8'h00, '0, 0);
    end
    bus.RWL = 8'h01; #1;
    chk("sweep_row0_const", bus.ToAdder, sweep_row0);

    // Row loads from the adder.
    for (int i = 0; i < ROWS; i++)
      cyc("rowload_hold", 0, 0, 0, 8'h00, 8'h00, 8'(1 << i), ROW_W'(i * 32), 0);
    for (int i = 0; i < ROWS; i++)
      adder_chk($sformatf("rowload_%0d", i), 8'(1 << i));
    bus.RWL = 8'h08; #1;
    chk("rowload_row3_const", bus.ToAdder, ROW_W'(96));
    adder_chk("rwl_or_0c", 8'h0C);
    adder_chk("rwl_zero", 8'h00);

    // Row write beats a host write to the same row.
    cyc("prio_wwl_hold", 1, 1, 0, 8'h20, 8'h5A, 8'h02, ones, 0);
    bus.RWL = 8'h02; #1;
    chk("prio_row1_ones", bus.ToAdder, ones);
    cyc("prio_byte_ff", 1, 0, 1, 8'h20, 8'h00, 8'h00, '0, 0);
    cyc("prio_clr_dout", 1, 1, 1, 8'h20, 8'h5A, 8'hFF, ones, 1);
    adder_chk("prio_clr_array", 8'hFF);

    // Same-address read and write.
    cyc("rw_setup", 1, 1, 0, 8'h10, 8'h11, 8'h00, '0, 0);
    cyc("rw_same_addr", 1, 1, 1, 8'h10, 8'h22, 8'h00, '0, 0);
`ifdef MEMV_BYPASS_EN
    chk("rw_same_const", ROW_W'(bus.DataOut), ROW_W'(8'h22));
`else
    chk("rw_same_const", ROW_W'(bus.DataOut), ROW_W'(8'h11));
`endif
    cyc("rw_after", 1, 0, 1, 8'h10, 8'h00, 8'h00, '0, 0);

    // Row write into the row being read by the host.
    cyc("fwd_setup", 1, 1, 0, 8'h05, 8'h77, 8'h00, '0, 0);
    cyc("fwd_wwl_rd", 1, 1, 1, 8'h05, 8'h99, 8'h01, pat, 0);
    cyc("fwd_after", 1, 0, 1, 8'h05, 8'h00, 8'h00, '0, 0);

    // En low ignores Write and READ.
    cyc("en0_hold", 0, 1, 1, 8'h05, 8'h99, 8'h00, '0, 0);
    cyc("en0_unchanged", 1, 0, 1, 8'h05, 8'h00, 8'h00, '0, 0);
    cyc("dout_hold", 1, 0, 0, 8'h10, 8'h00, 8'h00, '0, 0);

    // Async reset between edges during a row write.
    bus.WWL = 8'h01; bus.FromAdder = ones; bus.RWL = 8'hFF;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", ROW_W'(bus.DataOut), '0);
    chk("async_rst_toadder", bus.ToAdder, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.WWL = '0;
    cyc("post_rst_rd", 1, 0, 1, 8'h05, 8'h00, 8'h00, '0, 0);
    adder_chk("post_rst_toadder", 8'hFF);

    if (exp_q.size() != 0) chk("scoreboard_leftover", ROW_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
